// File: rtl/rapcore_io_pkg.sv
// rapcore_io_pkg: shared constants for the rapcore SPI-driven user I/O port.
package rapcore_io_pkg;

  localparam int unsigned FRAME_W = 8;

  localparam logic [FRAME_W-1:0] OP_WRITE_OUT = 8'h01;
  localparam logic [FRAME_W-1:0] OP_WRITE_OEB = 8'h02;
  localparam logic [FRAME_W-1:0] OP_READ_OUT  = 8'h81;
  localparam logic [FRAME_W-1:0] OP_READ_IN   = 8'h83;

  // Legacy state encodings, kept so existing decode/debug tooling still matches.
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CMD  = 2'd1;
  localparam logic [1:0] ST_DATA = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CMD  = ST_CMD,
    DATA = ST_DATA,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/rapcore_spi_sync.sv
// rapcore_spi_sync: 2-FF synchronizers for SCK/CS/COPI plus SCK edge and
// CS falling-edge detection in the CLK domain.
module rapcore_spi_sync (
  input  logic clk,
  input  logic rst,
  input  logic sck,
  input  logic cs,
  input  logic copi,
  output logic sck_rise,
  output logic sck_fall,
  output logic cs_s,
  output logic cs_fall,
  output logic copi_s
);

  logic [1:0] sck_ff;
  logic [1:0] cs_ff;
  logic [1:0] copi_ff;
  logic       sck_d;
  logic       cs_d;

  // Two-stage synchronizers and one-cycle delayed copies for edge detection.
  // Everything resets low so a CS held low through reset never looks like a
  // fresh falling edge; the host must re-assert CS to start a frame.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sck_ff  <= '0;
      cs_ff   <= '0;
      copi_ff <= '0;
      sck_d   <= 1'b0;
      cs_d    <= 1'b0;
    end else begin
      sck_ff  <= {sck_ff[0], sck};
      cs_ff   <= {cs_ff[0], cs};
      copi_ff <= {copi_ff[0], copi};
      sck_d   <= sck_ff[1];
      cs_d    <= cs_ff[1];
    end
  end

  assign sck_rise = sck_ff[1] & ~sck_d;
  assign sck_fall = ~sck_ff[1] & sck_d;
  assign cs_s     = cs_ff[1];
  assign cs_fall  = ~cs_ff[1] & cs_d;
  assign copi_s   = copi_ff[1];

endmodule

// File: rtl/rapcore_io_port_ctrl.sv
// rapcore_io_port_ctrl: SPI target (mode 0) that writes/reads an 8-bit user
// I/O port. Frame = opcode byte + data byte under CS low.
// Build option: define RAPCORE_CIPO_EN to include the READ_OUT/READ_IN
// readback path; without it CIPO is tied low and reads act as unknown opcodes.
module rapcore_io_port_ctrl
  import rapcore_io_pkg::*;
#(
  parameter logic [7:0] OUT_RESET = 8'h00,
  parameter logic [7:0] OEB_RESET = 8'hFF
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       SCK,
  input  logic       CS,
  input  logic       COPI,
  output logic       CIPO,
  input  logic [7:0] gpio_in,
  output logic [7:0] io_out,
  output logic [7:0] io_oeb,
  output logic       frame_done
);

  localparam logic [2:0] LAST_BIT = 3'd7;

  logic               sck_rise;
  logic               sck_fall;
  logic               cs_s;
  logic               cs_fall;
  logic               copi_s;
  state_t             state;
  logic [2:0]         bit_cnt;
  logic [FRAME_W-1:0] shift_in;
  logic [FRAME_W-1:0] opcode;
  logic [FRAME_W-1:0] byte_next;

  rapcore_spi_sync u_sync (
    .clk      (CLK),
    .rst      (RESET),
    .sck      (SCK),
    .cs       (CS),
    .copi     (COPI),
    .sck_rise (sck_rise),
    .sck_fall (sck_fall),
    .cs_s     (cs_s),
    .cs_fall  (cs_fall),
    .copi_s   (copi_s)
  );

  assign byte_next = {shift_in[FRAME_W-2:0], copi_s};

  // Frame FSM, receive shifter and output registers. CS high is checked
  // first so a CS rise racing the last data edge aborts the frame.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      shift_in   <= '0;
      opcode     <= '0;
      io_out     <= OUT_RESET;
      io_oeb     <= OEB_RESET;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (cs_s) begin
        state    <= IDLE;
        bit_cnt  <= '0;
        shift_in <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (cs_fall) begin
              state   <= CMD;
              bit_cnt <= '0;
            end
          end
          CMD: begin
            if (sck_rise) begin
              shift_in <= byte_next;
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == LAST_BIT) begin
                opcode <= byte_next;
                state  <= DATA;
              end
            end
          end
          DATA: begin
            if (sck_rise) begin
              shift_in <= byte_next;
              bit_cnt  <= bit_cnt + 3'd1;
              if (bit_cnt == LAST_BIT) begin
                state      <= DONE;
                frame_done <= 1'b1;
                if (opcode == OP_WRITE_OUT) io_out <= byte_next;
                if (opcode == OP_WRITE_OEB) io_oeb <= byte_next;
              end
            end
          end
          DONE:    state <= DONE;
          default: state <= IDLE;
        endcase
      end
    end
  end

`ifdef RAPCORE_CIPO_EN
  logic [7:0] gpio_ff;
  logic [7:0] gpio_s;
  logic [7:0] rd_byte;
  logic       cipo_r;
  logic       rd_op;

  assign rd_op = (opcode == OP_READ_OUT) || (opcode == OP_READ_IN);

  // Pad input synchronizer feeding the READ_IN snapshot.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      gpio_ff <= '0;
      gpio_s  <= '0;
    end else begin
      gpio_ff <= gpio_in;
      gpio_s  <= gpio_ff;
    end
  end

  // Readback: the MSB is driven as soon as the opcode completes; each SCK
  // fall in DATA then presents bit (7 - rises seen), so the first fall
  // re-presents the MSB instead of advancing past it.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      rd_byte <= '0;
      cipo_r  <= 1'b0;
    end else if (cs_s) begin
      cipo_r <= 1'b0;
    end else if (state == CMD && sck_rise && bit_cnt == LAST_BIT) begin
      if (byte_next == OP_READ_OUT) begin
        rd_byte <= io_out;
        cipo_r  <= io_out[7];
      end else if (byte_next == OP_READ_IN) begin
        rd_byte <= gpio_s;
        cipo_r  <= gpio_s[7];
      end else begin
        rd_byte <= '0;
        cipo_r  <= 1'b0;
      end
    end else if (state == DATA && sck_rise && bit_cnt == LAST_BIT) begin
      cipo_r <= 1'b0;
    end else if (state == DATA && sck_fall && rd_op) begin
      cipo_r <= rd_byte[~bit_cnt];
    end else if (state != DATA) begin
      cipo_r <= 1'b0;
    end
  end

  assign CIPO = cipo_r;
`else
  logic unused_rd;
  assign unused_rd = ^{gpio_in, sck_fall};
  assign CIPO      = 1'b0;
`endif

endmodule

// File: tb/tb_rapcore_io_port_ctrl.sv
// tb_rapcore_io_port_ctrl: directed SPI frames with hand-computed expectations.
module tb_rapcore_io_port_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       sck;
  logic       cs;
  logic       copi;
  logic       cipo;
  logic [7:0] gpio_in;
  logic [7:0] io_out;
  logic [7:0] io_oeb;
  logic       frame_done;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   fd_cnt   = 0;
  logic cipo_hi  = 1'b0;

  rapcore_io_port_ctrl #(
    .OUT_RESET (8'h00),
    .OEB_RESET (8'hFF)
  ) dut (
    .CLK        (clk),
    .RESET      (rst),
    .SCK        (sck),
    .CS         (cs),
    .COPI       (copi),
    .CIPO       (cipo),
    .gpio_in    (gpio_in),
    .io_out     (io_out),
    .io_oeb     (io_oeb),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (frame_done) fd_cnt++;
    if (cipo) cipo_hi = 1'b1;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic spi_byte(input logic [7:0] tx, output logic [7:0] rx);
    for (int i = 7; i >= 0; i--) begin
      copi = tx[i];
      #50 sck = 1'b1;
      rx[i] = cipo;
      #50 sck = 1'b0;
    end
  endtask

  task automatic frame(input logic [7:0] op, input logic [7:0] dat, output logic [7:0] rx);
    logic [7:0] dummy;
    cs = 1'b0;
    #50;
    spi_byte(op, dummy);
    spi_byte(dat, rx);
    #50 cs = 1'b1;
    #100;
  endtask

  initial begin
    logic [7:0] rx;
    logic [7:0] vals [12];
    logic [7:0] part;
    int         base;

    vals = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06,
             8'h07, 8'h08, 8'h09, 8'h0A, 8'hFF, 8'h00};
    rst = 1'b1; cs = 1'b1; sck = 1'b0; copi = 1'b0; gpio_in = 8'h00;
    #100;
    check("reset_io_out", io_out, 8'h00);
    check("reset_io_oeb", io_oeb, 8'hFF);
    check("reset_cipo", cipo, 1'b0);
    check("reset_frame_done", frame_done, 1'b0);
    rst = 1'b0;
    #100;
    check("reset_no_pulse", fd_cnt, 0);

    frame(8'h02, 8'h00, rx);
    check("oeb_write", io_oeb, 8'h00);
    check("oeb_pulse", fd_cnt, 1);

    foreach (vals[k]) begin
      base = fd_cnt;
      frame(8'h01, vals[k], rx);
      check("out_step", io_out, vals[k]);
      check("out_pulse", fd_cnt, base + 1);
    end
    check("oeb_held", io_oeb, 8'h00);

    frame(8'h01, 8'hA5, rx);
    check("out_a5", io_out, 8'hA5);
`ifdef RAPCORE_CIPO_EN
    frame(8'h81, 8'h00, rx);
    check("read_out", rx, 8'hA5);
    check("read_out_keeps", io_out, 8'hA5);
    gpio_in = 8'h3C;
    #100;
    frame(8'h83, 8'h00, rx);
    check("read_in", rx, 8'h3C);
    check("cipo_idle", cipo, 1'b0);
`else
    cipo_hi = 1'b0;
    frame(8'h81, 8'h00, rx);
    check("noread_cipo", cipo_hi, 1'b0);
    check("noread_rx", rx, 8'h00);
    check("noread_out", io_out, 8'hA5);
    check("noread_oeb", io_oeb, 8'h00);
`endif

    frame(8'h55, 8'h77, rx);
    check("unk_out", io_out, 8'hA5);
    check("unk_oeb", io_oeb, 8'h00);

    base = fd_cnt;
    cs = 1'b0;
    #50;
    spi_byte(8'h01, rx);
    spi_byte(8'h5A, rx);
    spi_byte(8'h11, rx);
    spi_byte(8'h22, rx);
    #50 cs = 1'b1;
    #100;
    check("extra_out", io_out, 8'h5A);
    check("extra_pulse", fd_cnt, base + 1);

    base = fd_cnt;
    part = 8'hC3;
    cs = 1'b0;
    #50;
    spi_byte(8'h01, rx);
    for (int i = 7; i >= 3; i--) begin
      copi = part[i];
      #50 sck = 1'b1;
      #50 sck = 1'b0;
    end
    #50 cs = 1'b1;
    #100;
    check("abort_out", io_out, 8'h5A);
    check("abort_pulse", fd_cnt, base);
    frame(8'h01, 8'h3C, rx);
    check("after_abort_out", io_out, 8'h3C);
    check("after_abort_pulse", fd_cnt, base + 1);

    frame(8'h02, 8'hFF, rx);
    check("oeb_ff", io_oeb, 8'hFF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
